// File: rtl/alu_arbiter.sv
// Round-robin arbiter that lets two requesters share one external ALU through an IDLE/SETUP/EXEC/DONE sequence.
// Optional feature: define ALU_ARB_PER_REQ_CARRY_EN to give each requester its own stored carry.
module alu_arbiter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_a,
  input  logic             req_b,
  input  logic [2:0]       op_a,
  input  logic [2:0]       op_b,
  input  logic [WIDTH-1:0] opnd1_a,
  input  logic [WIDTH-1:0] opnd2_a,
  input  logic [WIDTH-1:0] opnd1_b,
  input  logic [WIDTH-1:0] opnd2_b,
  output logic             done_a,
  output logic             done_b,
  output logic [WIDTH-1:0] result,
  output logic             carry_flag,
  output logic             zero_flag,
  output logic             busy,
  output logic [WIDTH-1:0] alu_in_1,
  output logic [WIDTH-1:0] alu_in_2,
  output logic [2:0]       alu_select,
  output logic             alu_enable,
  output logic             alu_carry_in,
  input  logic [WIDTH-1:0] alu_data,
  input  logic             alu_carry_out,
  input  logic             alu_zero,
  output logic [1:0]       state_dbg
);

  // Requester handshake: req is held high until its done pulse; operands and op
  // are only sampled on the grant edge, so later changes on the inputs are ignored.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    EXEC  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic             take_a;
  logic             take_b;
  logic             owner_b_q;
  logic             prio_b_q;
  logic [2:0]       op_q;
  logic [WIDTH-1:0] opnd1_q;
  logic [WIDTH-1:0] opnd2_q;
  logic             op_sets_carry;
  logic             stored_carry;
  logic             active;

`ifdef ALU_ARB_PER_REQ_CARRY_EN
  logic carry_a_q;
  logic carry_b_q;
`endif

  always_comb begin
    state_d = state_q;
    take_a  = 1'b0;
    take_b  = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_a && (!req_b || !prio_b_q)) begin
          take_a = 1'b1;
        end else if (req_b) begin
          take_b = 1'b1;
        end
        if (take_a || take_b) begin
          state_d = SETUP;
        end
      end
      SETUP:   state_d = EXEC;
      EXEC:    state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // add-with-carry, sub, inc and dec (codes 0,1,6,7) are the only carry producers
  assign op_sets_carry = (op_q[2] == op_q[1]);

`ifdef ALU_ARB_PER_REQ_CARRY_EN
  assign stored_carry = owner_b_q ? carry_b_q : carry_a_q;
`else
  assign stored_carry = carry_flag;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      owner_b_q  <= 1'b0;
      prio_b_q   <= 1'b0;
      op_q       <= 3'd0;
      opnd1_q    <= '0;
      opnd2_q    <= '0;
      result     <= '0;
      carry_flag <= 1'b0;
      zero_flag  <= 1'b0;
`ifdef ALU_ARB_PER_REQ_CARRY_EN
      carry_a_q  <= 1'b0;
      carry_b_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      if (take_a) begin
        owner_b_q <= 1'b0;
        prio_b_q  <= 1'b1;
        op_q      <= op_a;
        opnd1_q   <= opnd1_a;
        opnd2_q   <= opnd2_a;
      end else if (take_b) begin
        owner_b_q <= 1'b1;
        prio_b_q  <= 1'b0;
        op_q      <= op_b;
        opnd1_q   <= opnd1_b;
        opnd2_q   <= opnd2_b;
      end
      // ALU outputs are only trusted while alu_enable is high, i.e. in EXEC
      if (state_q == EXEC) begin
        result    <= alu_data;
        zero_flag <= alu_zero;
`ifdef ALU_ARB_PER_REQ_CARRY_EN
        if (op_sets_carry) begin
          carry_flag <= alu_carry_out;
          if (owner_b_q) begin
            carry_b_q <= alu_carry_out;
          end else begin
            carry_a_q <= alu_carry_out;
          end
        end else begin
          carry_flag <= stored_carry;
        end
`else
        if (op_sets_carry) begin
          carry_flag <= alu_carry_out;
        end
`endif
      end
    end
  end

  assign active       = (state_q != IDLE);
  assign busy         = active;
  assign alu_enable   = (state_q == EXEC);
  assign alu_in_1     = active ? opnd1_q : '0;
  assign alu_in_2     = active ? opnd2_q : '0;
  assign alu_select   = active ? op_q : 3'd0;
  assign alu_carry_in = active && (op_q == 3'd0) && stored_carry;
  assign done_a       = (state_q == DONE) && !owner_b_q;
  assign done_b       = (state_q == DONE) && owner_b_q;
  assign state_dbg    = state_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: a behavioural ALU answers the bus, each task checks one scenario.
// Honours ALU_ARB_PER_REQ_CARRY_EN for the carry-ownership scenario.
module tb_alu_arbiter;

  logic        clk;
  logic        reset;
  logic        req_a, req_b;
  logic [2:0]  op_a, op_b;
  logic [15:0] opnd1_a, opnd2_a, opnd1_b, opnd2_b;
  logic        done_a, done_b;
  logic [15:0] result;
  logic        carry_flag, zero_flag, busy;
  logic [15:0] alu_in_1, alu_in_2;
  logic [2:0]  alu_select;
  logic        alu_enable, alu_carry_in;
  logic [15:0] alu_data;
  logic        alu_carry_out, alu_zero;
  logic [1:0]  state_dbg;

  int total = 0;
  int bad   = 0;

  alu_arbiter #(.WIDTH(16)) dut (
    .clk(clk), .reset(reset),
    .req_a(req_a), .req_b(req_b), .op_a(op_a), .op_b(op_b),
    .opnd1_a(opnd1_a), .opnd2_a(opnd2_a), .opnd1_b(opnd1_b), .opnd2_b(opnd2_b),
    .done_a(done_a), .done_b(done_b), .result(result),
    .carry_flag(carry_flag), .zero_flag(zero_flag), .busy(busy),
    .alu_in_1(alu_in_1), .alu_in_2(alu_in_2), .alu_select(alu_select),
    .alu_enable(alu_enable), .alu_carry_in(alu_carry_in),
    .alu_data(alu_data), .alu_carry_out(alu_carry_out), .alu_zero(alu_zero),
    .state_dbg(state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ALU; outside EXEC it drives junk so stray captures show up.
  logic [16:0] alu_wide;
  always_comb begin
    alu_wide = 17'd0;
    case (alu_select)
      3'd0: alu_wide = {1'b0, alu_in_1} + {1'b0, alu_in_2} + {16'd0, alu_carry_in};
      3'd1: alu_wide = {1'b0, alu_in_1} - {1'b0, alu_in_2};
      3'd2: alu_wide = {1'b0, alu_in_1 & alu_in_2};
      3'd3: alu_wide = {1'b0, alu_in_1 | alu_in_2};
      3'd4: alu_wide = {1'b0, alu_in_1 ^ alu_in_2};
      3'd5: alu_wide = {1'b0, ~alu_in_1};
      3'd6: alu_wide = {1'b0, alu_in_1} + 17'd1;
      default: alu_wide = {1'b0, alu_in_1} - 17'd1;
    endcase
    if (alu_enable) begin
      alu_data      = alu_wide[15:0];
      alu_carry_out = alu_wide[16];
      alu_zero      = (alu_wide[15:0] == 16'd0);
    end else begin
      alu_data      = 16'hDEAD;
      alu_carry_out = 1'b1;
      alu_zero      = 1'b1;
    end
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    req_a = 1'b0;
    req_b = 1'b0;
    step();
    step();
    reset = 1'b0;
  endtask

  // Runs one operation from a single requester; returns the cycle of its done,
  // the number of alu_enable cycles seen and whether both dones ever overlapped.
  task automatic do_op(input bit use_b, input logic [2:0] op, input logic [15:0] o1,
                       input logic [15:0] o2, output int done_cyc, output int en_cnt,
                       output bit overlap);
    if (use_b) begin
      op_b = op; opnd1_b = o1; opnd2_b = o2; req_b = 1'b1;
    end else begin
      op_a = op; opnd1_a = o1; opnd2_a = o2; req_a = 1'b1;
    end
    done_cyc = -1;
    en_cnt   = 0;
    overlap  = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      step();
      if (alu_enable) en_cnt++;
      if (done_a && done_b) overlap = 1'b1;
      if (use_b ? done_b : done_a) begin
        done_cyc = i;
        break;
      end
    end
    req_a = 1'b0;
    req_b = 1'b0;
    step();
  endtask

  task automatic test_reset();
    apply_reset();
    total++;
    if ({state_dbg, busy, done_a, done_b, alu_enable, alu_carry_in} !== 7'd0) begin
      bad++;
      $display("FAIL reset_ctrl: got state=%0d busy=%b done=%b%b en=%b cin=%b want all 0",
               state_dbg, busy, done_a, done_b, alu_enable, alu_carry_in);
    end
    total++;
    if ({result, carry_flag, zero_flag, alu_in_1, alu_in_2, alu_select} !== 53'd0) begin
      bad++;
      $display("FAIL reset_data: got result=%h c=%b z=%b in1=%h in2=%h sel=%0d want 0",
               result, carry_flag, zero_flag, alu_in_1, alu_in_2, alu_select);
    end
  endtask

  task automatic test_basic_add();
    int dc, en;
    bit ov;
    apply_reset();
    do_op(1'b0, 3'd0, 16'h0001, 16'h0002, dc, en, ov);
    total++;
    if (dc !== 3) begin bad++; $display("FAIL basic_latency: got %0d want 3", dc); end
    total++;
    if (en !== 1) begin bad++; $display("FAIL basic_enable_cycles: got %0d want 1", en); end
    total++;
    if ({result, carry_flag, zero_flag} !== {16'h0003, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL basic_result: got %h c=%b z=%b want 0003 c=0 z=0", result, carry_flag, zero_flag);
    end
    total++;
    if (state_dbg !== 2'd0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL basic_idle_after: got state=%0d busy=%b want 0 0", state_dbg, busy);
    end
  endtask

  task automatic test_carry_chain();
    int dc, en;
    bit ov;
    apply_reset();
    do_op(1'b0, 3'd0, 16'hFFFF, 16'h0001, dc, en, ov);
    total++;
    if ({result, carry_flag, zero_flag} !== {16'h0000, 1'b1, 1'b1}) begin
      bad++;
      $display("FAIL carry_overflow: got %h c=%b z=%b want 0000 c=1 z=1", result, carry_flag, zero_flag);
    end
    do_op(1'b0, 3'd0, 16'h0000, 16'h0000, dc, en, ov);
    total++;
    if ({result, carry_flag, zero_flag} !== {16'h0001, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL carry_in_used: got %h c=%b z=%b want 0001 c=0 z=0", result, carry_flag, zero_flag);
    end
  endtask

  task automatic test_and_keeps_carry();
    int dc, en;
    bit ov;
    apply_reset();
    do_op(1'b0, 3'd0, 16'hFFFF, 16'h0001, dc, en, ov);
    do_op(1'b0, 3'd2, 16'hF0F0, 16'h0F0F, dc, en, ov);
    total++;
    if ({result, carry_flag, zero_flag} !== {16'h0000, 1'b1, 1'b1}) begin
      bad++;
      $display("FAIL and_keeps_carry: got %h c=%b z=%b want 0000 c=1 z=1", result, carry_flag, zero_flag);
    end
    do_op(1'b1, 3'd1, 16'h0005, 16'h0007, dc, en, ov);
    total++;
    if ({result, carry_flag, zero_flag} !== {16'hFFFE, 1'b1, 1'b0}) begin
      bad++;
      $display("FAIL sub_borrow: got %h c=%b z=%b want fffe c=1 z=0", result, carry_flag, zero_flag);
    end
  endtask

  task automatic test_round_robin();
    logic exp_a, exp_b;
    apply_reset();
    op_a = 3'd0; opnd1_a = 16'h0001; opnd2_a = 16'h0001;
    op_b = 3'd0; opnd1_b = 16'h0003; opnd2_b = 16'h0004;
    req_a = 1'b1;
    req_b = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      step();
      exp_a = (i == 3) || (i == 11);
      exp_b = (i == 7) || (i == 15);
      total++;
      if (done_a !== exp_a || done_b !== exp_b) begin
        bad++;
        $display("FAIL rr_done_c%0d: got a=%b b=%b want a=%b b=%b", i, done_a, done_b, exp_a, exp_b);
      end
      if (exp_a || exp_b) begin
        total++;
        if (result !== (exp_a ? 16'h0002 : 16'h0007)) begin
          bad++;
          $display("FAIL rr_result_c%0d: got %h want %h", i, result, exp_a ? 16'h0002 : 16'h0007);
        end
      end
    end
    req_a = 1'b0;
    req_b = 1'b0;
  endtask

  task automatic test_back_to_back();
    apply_reset();
    op_a = 3'd0; opnd1_a = 16'h0001; opnd2_a = 16'h0002;
    req_a = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      step();
      total++;
      if (done_a !== ((i == 3) || (i == 7))) begin
        bad++;
        $display("FAIL b2b_done_c%0d: got %b want %b", i, done_a, (i == 3) || (i == 7));
      end
    end
    req_a = 1'b0;
  endtask

  task automatic test_inflight_change();
    apply_reset();
    op_a = 3'd0; opnd1_a = 16'h0002; opnd2_a = 16'h0003;
    req_a = 1'b1;
    step();
    op_a = 3'd2; opnd1_a = 16'h0100; opnd2_a = 16'h0000;
    req_a = 1'b0;
    step();
    step();
    total++;
    if (done_a !== 1'b1 || result !== 16'h0005) begin
      bad++;
      $display("FAIL inflight_change: got done=%b result=%h want done=1 result=0005", done_a, result);
    end
    step();
    total++;
    if (state_dbg !== 2'd0 || done_a !== 1'b0) begin
      bad++;
      $display("FAIL inflight_no_rerun: got state=%0d done=%b want 0 0", state_dbg, done_a);
    end
  endtask

  task automatic test_reset_in_exec();
    int dc, en;
    bit ov;
    bit seen_done;
    apply_reset();
    do_op(1'b0, 3'd0, 16'h0005, 16'h0006, dc, en, ov);
    op_a = 3'd0; opnd1_a = 16'hFFFF; opnd2_a = 16'h0001;
    req_a = 1'b1;
    step();
    step();
    total++;
    if (alu_enable !== 1'b1) begin bad++; $display("FAIL rexec_in_exec: got en=%b want 1", alu_enable); end
    reset = 1'b1;
    step();
    reset = 1'b0;
    req_a = 1'b0;
    total++;
    if ({state_dbg, alu_enable, done_a, done_b} !== 5'd0) begin
      bad++;
      $display("FAIL rexec_ctrl: got state=%0d en=%b done=%b%b want 0", state_dbg, alu_enable, done_a, done_b);
    end
    total++;
    if ({result, carry_flag, zero_flag} !== 18'd0) begin
      bad++;
      $display("FAIL rexec_data: got %h c=%b z=%b want 0000 c=0 z=0", result, carry_flag, zero_flag);
    end
    seen_done = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (done_a || done_b) seen_done = 1'b1;
    end
    total++;
    if (seen_done !== 1'b0) begin bad++; $display("FAIL rexec_no_done: got done pulse want none"); end
  endtask

  task automatic test_carry_owner();
    int dc, en;
    bit ov;
    apply_reset();
    do_op(1'b0, 3'd0, 16'hFFFF, 16'h0001, dc, en, ov);
    do_op(1'b1, 3'd0, 16'h0000, 16'h0000, dc, en, ov);
`ifdef ALU_ARB_PER_REQ_CARRY_EN
    total++;
    if ({result, carry_flag} !== {16'h0000, 1'b0}) begin
      bad++;
      $display("FAIL owner_b_own_carry: got %h c=%b want 0000 c=0", result, carry_flag);
    end
    do_op(1'b0, 3'd0, 16'h0000, 16'h0000, dc, en, ov);
    total++;
    if (result !== 16'h0001) begin bad++; $display("FAIL owner_a_kept_carry: got %h want 0001", result); end
`else
    total++;
    if ({result, carry_flag} !== {16'h0001, 1'b0}) begin
      bad++;
      $display("FAIL shared_b_uses_carry: got %h c=%b want 0001 c=0", result, carry_flag);
    end
    do_op(1'b0, 3'd0, 16'h0000, 16'h0000, dc, en, ov);
    total++;
    if (result !== 16'h0000) begin bad++; $display("FAIL shared_a_after_b: got %h want 0000", result); end
`endif
    total++;
    if (ov !== 1'b0) begin bad++; $display("FAIL owner_overlap: got overlap want none"); end
  endtask

  initial begin
    reset = 1'b1;
    req_a = 1'b0; req_b = 1'b0;
    op_a = 3'd0; op_b = 3'd0;
    opnd1_a = '0; opnd2_a = '0; opnd1_b = '0; opnd2_b = '0;
    test_reset();
    test_basic_add();
    test_carry_chain();
    test_and_keeps_carry();
    test_round_robin();
    test_back_to_back();
    test_inflight_change();
    test_reset_in_exec();
    test_carry_owner();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
